sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-requester front end for one single-port synchronous SRAM: 1-cycle registered read data, write strobe bus WEN of width DATA_WIDTH.
- Clears the whole array after reset, then arbitrates read/write requests round-robin with valid/ready handshakes.
- Routes each read result back to the requester that issued it.
- Sits between core-side clients (e.g. fetch and load/store) and the sram instance.

Parameters:
- DATA_WIDTH, 32, word width; equals the SRAM data and WEN width.
- ADDR_WIDTH, 10, address width; the array depth is 2**ADDR_WIDTH.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- init_done  output  1  high once the clear sweep finishes.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept.
- req_we  input  2  per-requester request type: 1 = write, 0 = read.
- req_addr  input  2*ADDR_WIDTH  per-requester address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  2*DATA_WIDTH  per-requester write data; sliced the same way.
- rsp_valid  output  2  per-requester read-data valid, one-cycle pulse.
- rsp_rdata  output  DATA_WIDTH  read data; shared, qualified by rsp_valid.
- sram_A  output  ADDR_WIDTH  to SRAM A.
- sram_D  output  DATA_WIDTH  to SRAM D.
- sram_WEN  output  DATA_WIDTH  to SRAM WEN: all-ones = write, all-zeros = no write.
- sram_Q  input  DATA_WIDTH  from SRAM Q.

Behaviour:
- Clock/reset: one clock (CLK). Reset RST is synchronous and active-high. All state is cleared on the CLK edge where RST=1.
- Reset values (registered outputs and state):
  - state=INIT, init_cnt=0, init_done=0.
  - rr_ptr=0 (requester 0 has priority first).
  - rd_pend=0, so rsp_valid=00.
  - While RST=1, req_ready=00 and sram_WEN=0.
- FSM has two states, INIT and RUN.
- INIT:
  - Each cycle drive sram_A=init_cnt, sram_D=0, sram_WEN=all-ones.
  - init_cnt increments each cycle.
  - When init_cnt = 2**ADDR_WIDTH-1, go to RUN next cycle. The sweep takes exactly 2**ADDR_WIDTH cycles.
  - req_ready=00 throughout INIT.
- RUN:
  - init_done=1.
  - Grant logic is combinational from req_valid and rr_ptr.
  - If only one requester is valid, it is granted.
  - If both are valid, requester rr_ptr is granted.
  - req_ready = grant vector. At most one bit is set; 00 if no request is valid.
  - req_ready must not depend on req_we or req_addr.
- On handshake (req_valid[i] & req_ready[i]) in cycle N:
  - sram_A = req_addr slice i.
  - Write: sram_D = req_wdata slice i, sram_WEN = all-ones.
  - Read: sram_WEN = 0, sram_D = don't-care (drive 0).
  - rr_ptr <= ~i (the other requester gets priority next). rr_ptr is unchanged if there is no handshake.
- Read response timing:
  - A read accepted in cycle N sets rd_pend=1 and rd_owner=i for cycle N+1.
  - In cycle N+1: rsp_valid[rd_owner]=1, rsp_rdata=sram_Q (combinational pass-through), other rsp_valid bit 0.
  - Latency is exactly 1 cycle. There is no response backpressure; requesters must sink it.
- Throughput: one request per cycle, sustained. Back-to-back reads from alternating requesters are legal: each read's response comes in the following cycle, overlapping the next accept.
- Reads with no handshake must not toggle sram_WEN. On idle cycles sram_A holds its last value and sram_WEN=0.
- Write-then-read to the same address in consecutive cycles returns the new data. The SRAM is single-port, so there is no bypass.
- Reset mid-operation:
  - Any pending read is dropped; rsp_valid=00 in the cycle after the RST edge.
  - FSM re-enters INIT and the full clear re-runs.
- A requester holding req_valid without ready keeps its request stable (AXI-style rule). The arbiter does not check this.
- Fairness: with both requesters continuously valid, grants alternate strictly 0,1,0,1…

Decomposition:
- Shared package sram_pkg holds:
  - state enum {INIT, RUN};
  - the NUM_REQ=2 constant;
  - the WEN_ALL / WEN_NONE constant helpers.
- One natural sub-module: rr_arb2. It is the combinational 2-way round-robin grant from (valid[1:0], rr_ptr) to grant[1:0].
- The FSM, init counter and response tracking live in sram_arbiter.

Test Plan:
- Reset, then hold RST=0 → req_ready=00 and sram_WEN=all-ones for 1024 cycles with sram_A 0..1023; init_done=1 at cycle 1024. Afterwards a read of any address returns 0.
- Requester 0 writes 0xDEADBEEF @0x005 → next cycle requester 0 reads 0x005 → rsp_valid=01 one cycle after accept, rsp_rdata=0xDEADBEEF.
- Both requesters continuously valid with reads @0x010 (r0) and @0x020 (r1), preloaded with 0x11 and 0x22 → grants alternate 01,10,01,10. Responses 0x11→r0 and 0x22→r1 each one cycle after their accept, never both rsp_valid bits high.
- Requester 1 writes 0xA5A5A5A5 @0x3FF, then reads it in the next cycle → rsp_rdata=0xA5A5A5A5 and rsp_valid=10.
- Read accepted in cycle N, RST=1 at edge N+1 → rsp_valid=00 in cycle N+1 onward; INIT restarts with init_done=0 and sram_A=0.
- Only requester 1 valid while rr_ptr=0 → granted immediately (req_ready=10) with no idle cycle.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the two-requester SRAM arbiter
package sram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NUM_REQ = 2;

  // Per-bit write-strobe levels; replicate to DATA_WIDTH at the point of use.
  localparam logic WEN_ALL  = 1'b1;
  localparam logic WEN_NONE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin grant
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = rr_ptr_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - clears a single-port SRAM after reset, then arbitrates
// two valid/ready requesters round-robin and routes read data back to its owner
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      CLK,
  input  logic                      RST,
  output logic                      init_done,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [ADDR_WIDTH-1:0]     sram_A,
  output logic [DATA_WIDTH-1:0]     sram_D,
  output logic [DATA_WIDTH-1:0]     sram_WEN,
  input  logic [DATA_WIDTH-1:0]     sram_Q
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0]   sram_a_q, sram_a_d;
  logic                    rr_ptr_q, rr_ptr_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    rd_owner_q, rd_owner_d;

  logic [1:0]              grant;
  logic                    gnt_idx;
  logic [ADDR_WIDTH-1:0]   gnt_addr;
  logic [DATA_WIDTH-1:0]   gnt_wdata;

  rr_arb2 u_rr_arb2 (
    .valid_i (req_valid),
    .rr_ptr_i(rr_ptr_q),
    .grant_o (grant)
  );

  assign gnt_idx   = grant[1];
  assign gnt_addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign gnt_wdata = gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    sram_a_d   = sram_a_q;
    rr_ptr_d   = rr_ptr_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    req_ready  = '0;
    sram_A     = sram_a_q;
    sram_D     = '0;
    sram_WEN   = {DATA_WIDTH{WEN_NONE}};

    case (state_q)
      INIT: begin
        sram_A     = init_cnt_q;
        sram_WEN   = {DATA_WIDTH{WEN_ALL}};
        sram_a_d   = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        req_ready = grant;
        if (|grant) begin
          sram_A   = gnt_addr;
          sram_a_d = gnt_addr;
          rr_ptr_d = ~gnt_idx;
          if (req_we[gnt_idx]) begin
            sram_D   = gnt_wdata;
            sram_WEN = {DATA_WIDTH{WEN_ALL}};
          end else begin
            rd_pend_d  = 1'b1;
            rd_owner_d = gnt_idx;
          end
        end
      end
      default: state_d = INIT;
    endcase

    // Nothing may be accepted or written while reset is asserted.
    if (RST) begin
      req_ready = '0;
      sram_WEN  = {DATA_WIDTH{WEN_NONE}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      sram_a_q   <= '0;
      rr_ptr_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sram_a_q   <= sram_a_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign init_done = (state_q == RUN);
  assign rsp_valid = (rd_pend_q && !RST) ? (rd_owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = sram_Q;

endmodule
